multibyte_adder_seq: RTL and testbench
======================================

Name: multibyte_adder_seq

Overview:
- Sequencer that time-shares one adder_8bit instance to add two NUM_BYTES-byte operands, one byte per clock, LSB byte first.
- Ripples the carry between bytes through an internal carry register.
- Uses a start/busy/done handshake.
- Sits between a control FSM and the 8-bit adder datapath, so wide additions run without widening the adder.

Parameters:
- NUM_BYTES, 4, operand width in bytes; legal range 2..16.
- CNT_BITS, $clog2(NUM_BYTES), width of the byte-index counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  8*NUM_BYTES  operand A; sampled on the accepted start.
- b  input  8*NUM_BYTES  operand B; sampled on the accepted start.
- carry_in  input  1  initial carry into byte 0; sampled on the accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/carry_out become valid.
- sum  output  8*NUM_BYTES  registered result.
- carry_out  output  1  registered carry out of the top byte.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, byte index=0, internal carry=0, busy=0, done=0, sum=0, carry_out=0, operand registers=0.
- FSM states are IDLE, ADD and DONE.
- IDLE:
  - If start=1 at a rising edge, latch a, b and carry_in into internal registers, clear the byte index and go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - Each cycle, drive adder_8bit with byte[idx] of latched A, byte[idx] of latched B, and the internal carry.
  - On the edge, write the adder sum into byte idx of a working result register and the adder overflow into the internal carry.
  - Then increment idx.
  - When idx=NUM_BYTES-1, on that edge: go to DONE, copy the full working result to sum, and copy the final overflow to carry_out.
- DONE: done=1 for exactly this one cycle; unconditionally return to IDLE next edge.
- busy = (state==ADD). It is registered-state decoded with no combinational path from start.
- Latency: start accepted at edge E0 → busy high cycles E0..E0+NUM_BYTES → done high in the cycle after edge E0+NUM_BYTES. Total NUM_BYTES+1 cycles start-to-done; next start can be accepted at the edge ending the DONE cycle + 1, i.e. in IDLE.
- sum and carry_out hold their last value until the next completion. They are never partially updated; the working register is internal.
- start while in ADD or DONE is ignored; it is not queued.
- Input operand changes after acceptance have no effect.
- rst asserted mid-operation aborts immediately: all registers return to reset values and no done pulse is issued.
- Arithmetic is unsigned modulo 2^(8*NUM_BYTES); carry_out is bit 8*NUM_BYTES of a+b+carry_in.

Optional Feature:
- Macro: MULTIBYTE_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1, latched B is stored bitwise-inverted and the initial carry is forced to 1; carry_in is ignored. Result = a-b mod 2^(8*NUM_BYTES).
  - carry_out=1 means no borrow (a>=b).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan (NUM_BYTES=4):
- Reset mid-run: start with a=0x0000_00FF, b=0x0000_0001; assert rst after 2 ADD cycles → busy=0, sum=0, carry_out=0 immediately; no done pulse follows.
- Basic add: a=0x1234_5678, b=0x1111_1111, carry_in=0, start pulse → busy 4 cycles, done pulse in cycle 5, sum=0x2345_6789, carry_out=0.
- Carry ripple/wrap: a=0xFFFF_FFFF, b=0x0000_0000, carry_in=1 → sum=0x0000_0000, carry_out=1. Internal carry propagates through all 4 bytes.
- Ignored start: hold start=1 continuously with a=0x0000_0001, b=0x0000_0001 and change a to 0x0000_0100 during ADD → result 0x0000_0002. A new op is accepted only on the first IDLE cycle after DONE; done pulses exactly once per accepted op.
- Result hold: after completion, wiggle a/b with start=0 for 20 cycles → sum/carry_out unchanged, busy=0, done=0.
- MULTIBYTE_SUB_EN: sub=1, a=0x0000_0005, b=0x0000_0007 → sum=0xFFFF_FFFE, carry_out=0. Then a=7, b=5 → sum=2, carry_out=1.

Source files
------------

// File: rtl/multibyte_adder_seq.sv
// multibyte_adder_seq: adds two NUM_BYTES-byte operands one byte per clock
// through a single shared adder_8bit, LSB byte first, with the carry rippled
// between bytes in a register. Handshake is start / busy / done.
// Optional build macro MULTIBYTE_SUB_EN adds a 'sub' input that turns the
// operation into a - b (carry_out = 1 means no borrow).

// 8-bit adder datapath shared across all byte positions.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign sum  = full[7:0];
  assign cout = full[8];
endmodule

module multibyte_adder_seq #(
  parameter  int NUM_BYTES = 4,
  localparam int CNT_BITS  = $clog2(NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  input  logic                   carry_in,
`ifdef MULTIBYTE_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] sum,
  output logic                   carry_out
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_BYTES - 1);

  state_t                        state_q, state_d;
  logic [CNT_BITS-1:0]           idx_q, idx_d;
  logic                          carry_q, carry_d;
  logic [NUM_BYTES-1:0][7:0]     a_q, a_d;
  logic [NUM_BYTES-1:0][7:0]     b_q, b_d;
  logic [NUM_BYTES-1:0][7:0]     work_q, work_d;
  logic [NUM_BYTES-1:0][7:0]     sum_q, sum_d;
  logic                          cout_q, cout_d;

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cout;

  // The shared adder always sees the byte selected by the current index.
  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q];

  adder_8bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath update: latch on start, one byte per ADD cycle,
  // publish the full result only on the last byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
`ifdef MULTIBYTE_SUB_EN
          // Two's complement subtract: invert B and inject a carry of one.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d[idx_q] = add_sum;
        carry_d       = add_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = work_d;
          cout_d  = add_cout;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CNT_BITS'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including operands and results, clears on asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Testbench for multibyte_adder_seq (NUM_BYTES=4). A cycle-count reference
// model predicts busy/done/sum/carry_out every cycle; directed cases pin the
// model with literal results. Build with MULTIBYTE_SUB_EN to cover subtract.
module tb_multibyte_adder_seq;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multibyte_adder_seq #(.NUM_BYTES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef MULTIBYTE_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after an accepted start, N cycles busy, then one done
  // cycle during which the new result is already visible.
  int           rem = 0;
  logic [W:0]   pend = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    = 0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
`ifdef MULTIBYTE_SUB_EN
        if (sub) pend = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`endif
        rem = N + 1;
      end
    end else begin
      rem--;
      if (rem == 1) begin
        m_sum  = pend[W-1:0];
        m_cout = pend[W];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", busy, (rem >= 2));
    chk("done", done, (rem == 1));
    chk("sum", sum, m_sum);
    chk("carry_out", carry_out, m_cout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the done cycle; returns busy cycles seen and cycles waited.
  task automatic wait_done(output int busy_cyc, output int lat);
    busy_cyc = 0;
    lat      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (done) break;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, input logic s,
                        output int busy_cyc, output int lat);
    a = aa; b = bb; carry_in = ci; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(busy_cyc, lat);
  endtask

  int           bc, lat;
  logic         seen;
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sum", sum, 32'h0);
    chk("reset_cout", carry_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Basic add
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, bc, lat);
    chk("basic_sum", sum, 32'h2345_6789);
    chk("basic_cout", carry_out, 1'b0);
    chk("basic_busy_cycles", bc, 4);
    chk("basic_latency", lat, 5);
    tick();

    // Carry ripple through every byte
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, bc, lat);
    chk("ripple_sum", sum, 32'h0000_0000);
    chk("ripple_cout", carry_out, 1'b1);
    tick();

    // Reset in the middle of an operation
    a = 32'h0000_00FF; b = 32'h0000_0001; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_cout", carry_out, 1'b0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);
    tick();

    // Start held high; operand change during ADD must not matter
    a = 32'h0000_0001; b = 32'h0000_0001; carry_in = 1'b0; start = 1'b1;
    tick();
    a = 32'h0000_0100;
    wait_done(bc, lat);
    chk("held_start_sum", sum, 32'h0000_0002);
    @(negedge clk);
    chk("held_start_idle_gap", busy, 1'b0);
    chk("held_start_no_redone", done, 1'b0);
    @(negedge clk);
    chk("held_start_reaccept", busy, 1'b1);
    start = 1'b0;
    wait_done(bc, lat);
    chk("held_start_second_sum", sum, 32'h0000_0101);
    tick();

    // Result hold with wiggling inputs and no start
    hold_sum  = sum;
    hold_cout = carry_out;
    repeat (20) begin
      a = $urandom; b = $urandom; carry_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("hold_sum", sum, hold_sum);
    chk("hold_cout", carry_out, hold_cout);
    chk("hold_busy", busy, 1'b0);
    chk("hold_done", done, 1'b0);

`ifdef MULTIBYTE_SUB_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, bc, lat);
    chk("sub_neg_sum", sum, 32'hFFFF_FFFE);
    chk("sub_neg_cout", carry_out, 1'b0);
    tick();
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, bc, lat);
    chk("sub_pos_sum", sum, 32'h0000_0002);
    chk("sub_pos_cout", carry_out, 1'b1);
    tick();
`endif

    // Randomized traffic, checked every cycle by the model
    repeat (400) begin
      a        = $urandom;
      b        = $urandom;
      carry_in = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 3) == 0);
`ifdef MULTIBYTE_SUB_EN
      sub      = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    start = 1'b0;
    repeat (N + 3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
